aes_inv_subbytes_iter: RTL
==========================

// Module: aes_inv_subbytes_iter
// PURPOSE
//  Iterative AES InvSubBytes engine for the decryption datapath. It is the inverse of the forward S-box byte substitution.
//  Accepts one 128-bit state over a valid/ready handshake and replaces each byte b with InvSBox(b) (FIPS-197 Fig.14), LANES bytes per cycle.
//  Returns the result over a valid/ready handshake. Sits between InvShiftRows and AddRoundKey in the decrypt round loop.
// PARAMETERS
//  LANES  4  bytes substituted per clock; legal values 1,2,4,8,16; any other value is a compile-time error ($error in generate)
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    in_state is valid this cycle
//  in_ready   out  1    engine can accept a state (high only in IDLE)
//  in_state   in   128  ciphertext-side state; byte0 = [127:120] ... byte15 = [7:0]
//  out_valid  out  1    out_state holds a completed result
//  out_ready  in   1    consumer accepts out_state this cycle
//  out_state  out  128  substituted state; same byte order; 128'h0 whenever out_valid=0
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Internal 256x8 inverse S-box table, combinational read, LANES instances (one per lane).
//  - GROUPS = 16/LANES; group counter cnt is $clog2(GROUPS) bits wide (min 1 bit) and resets to 0.
//  - FSM states: IDLE, RUN, DONE. Reset -> IDLE, cnt=0, state_reg=0. After reset: in_ready=1, out_valid=0, busy=0, out_state=0.
//  - IDLE:
//      - in_ready=1.
//      - On in_valid&&in_ready: state_reg<=in_state, cnt<=0, go to RUN.
//      - in_valid=0 holds IDLE.
//  - RUN:
//      - Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of state_reg are replaced by their InvSBox values.
//      - cnt increments by 1.
//      - When cnt==GROUPS-1 this cycle, go to DONE and set cnt<=0.
//      - in_ready=0. in_valid is ignored (no queueing).
//  - DONE:
//      - out_valid=1, out_state=state_reg.
//      - On out_ready: go to IDLE.
//      - With out_ready=0: hold DONE indefinitely; out_state stays bit-stable (no substitution is re-applied).
//  - Latency: accept edge at cycle T gives out_valid=1 at cycle T+GROUPS (LANES=4: 4 cycles; LANES=16: 1 cycle; LANES=1: 16 cycles).
//  - Throughput: at most one state per GROUPS+2 cycles.
//      - The cycle after the out handshake is IDLE, so back-to-back acceptance is not possible.
//      - in_ready is low in the cycle out_valid&&out_ready completes.
//  - Each byte is substituted exactly once per operation; untouched bytes pass through unchanged until their group is processed.
//  - Reset mid-RUN or mid-DONE:
//      - The operation is discarded; nothing is emitted.
//      - IDLE with zeroed registers on the next cycle.
//  - in_ready, out_valid and busy are decoded from the registered FSM state only, with no combinational path from in_valid or out_ready.
// TESTING
//  1) Reset, then in_state=128'h63636363636363636363636363636363, in_valid=1 -> after 4 cycles out_valid=1, out_state=128'h0.
//  2) in_state=128'h637c777bf26b6fc53001672bfed7ab76 -> out_state=128'h000102030405060708090a0b0c0d0e0f.
//  3) Exhaustive round-trip: for all b in 0..255, feed forward-S-box(b) replicated 16x -> out_state = b replicated 16x.
//     Also spot-check InvSBox(00)=52, (16)=ff, (52)=48.
//  4) Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_state constant, in_ready=0.
//     Drop in_valid pulses while busy -> no effect on result.
//  5) Assert rst during RUN at cnt=2 -> next cycle in_ready=1, out_valid=0, out_state=0.
//     A new state is then processed correctly.
//  6) Parameter sweep LANES=1,2,8,16 with vector 2 -> same result; out_valid latency = 16,8,2,1 cycles.

Source files
------------

// File: rtl/aes_inv_subbytes_iter.sv
// Iterative AES InvSubBytes engine: substitutes LANES bytes of a 128-bit state per
// clock through the inverse S-box, with valid/ready handshakes on both sides.
module aes_inv_subbytes_iter #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int unsigned GROUPS = 16 / LANES;
   localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("aes_inv_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   // Inverse S-box, entry 0x00 in the top byte, 16 entries per row
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[2047 - 8 * 32'(b) -: 8];
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         fsm;
   logic [CW-1:0]  cnt;
   logic [127:0]   state_reg;
   logic [7:0]     sub [LANES];

   // One table read per lane, on the group selected by cnt
   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         sub[l] = inv_sbox(state_reg[127 - 8 * (32'(cnt) * LANES + l) -: 8]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= IDLE;
         cnt       <= '0;
         state_reg <= '0;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= in_state;
                  cnt       <= '0;
                  fsm       <= RUN;
               end
            end
            RUN: begin
               for (int unsigned l = 0; l < LANES; l++) begin
                  state_reg[127 - 8 * (32'(cnt) * LANES + l) -: 8] <= sub[l];
               end
               if (cnt == CW'(GROUPS - 1)) begin
                  cnt <= '0;
                  fsm <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) fsm <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   // Handshake flags depend on the registered state only
   assign in_ready  = (fsm == IDLE);
   assign out_valid = (fsm == DONE);
   assign busy      = (fsm == RUN) || (fsm == DONE);
   assign out_state = (fsm == DONE) ? state_reg : '0;

endmodule
